// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed DIGITS-wide hex display driver.
// A prescaled scan counter steps one digit per PRESCALE cycles. A
// ready/load handshake captures the value to show next. Optional
// leading-zero blanking is included.
// Optional feature macro: SEG_SCAN_DP_EN adds the dp_mask input and the
// dp output (decimal point per digit).
module seg_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
`ifdef SEG_SCAN_DP_EN
    input  logic [DIGITS-1:0]     dp_mask,
    output logic                  dp,
`endif
    output logic                  ready,
    output logic                  upd_done,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

    logic [PW-1:0]         pcnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   disp_reg;
    logic [4*DIGITS-1:0]   pend_reg;
    logic                  pend;
    logic                  xfer_d;
    logic                  tick;
    logic                  wrap;
    logic [3:0]            nib;
    logic [DIGITS-1:0]     zero_up;
    logic                  blank_now;
    logic [DIGITS-1:0]     an_next;
`ifdef SEG_SCAN_DP_EN
    logic [DIGITS-1:0]     pend_dp;
    logic [DIGITS-1:0]     disp_dp;
`endif

    // Hex nibble to active-high segments {a,b,c,d,e,f,g}.
    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        case (n)
            4'h0: hex_decode = 7'h7E;
            4'h1: hex_decode = 7'h30;
            4'h2: hex_decode = 7'h6D;
            4'h3: hex_decode = 7'h79;
            4'h4: hex_decode = 7'h33;
            4'h5: hex_decode = 7'h5B;
            4'h6: hex_decode = 7'h5F;
            4'h7: hex_decode = 7'h70;
            4'h8: hex_decode = 7'h7F;
            4'h9: hex_decode = 7'h7B;
            4'hA: hex_decode = 7'h77;
            4'hB: hex_decode = 7'h1F;
            4'hC: hex_decode = 7'h4E;
            4'hD: hex_decode = 7'h3D;
            4'hE: hex_decode = 7'h4F;
            default: hex_decode = 7'h47;
        endcase
    endfunction

    // Handshake: ready is high exactly when no value is pending. A load
    // sampled with ready=1 at a rising edge is accepted. A load sampled with
    // ready=0 is dropped, and the requester must retry later.
    assign ready = ~pend;

    // Slot end and frame end (wrap) strobes; both are qualified by en.
    always_comb begin
        tick = en && (pcnt == PMAX);
        wrap = tick && (idx == IMAX);
    end

    // Prescaler and digit index; both hold while scanning is disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (en) begin
            if (tick) begin
                pcnt <= '0;
                idx  <= (idx == IMAX) ? '0 : idx + IW'(1);
            end else begin
                pcnt <= pcnt + PW'(1);
            end
        end
    end

    // Load capture and frame-boundary transfer. A wrap with pend=1 moves
    // the pending value into the display. The pulse is delayed twice so
    // that upd_done lines up with the first registered output of the new
    // digit 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_reg <= '0;
            pend_reg <= '0;
            pend     <= 1'b0;
            xfer_d   <= 1'b0;
            upd_done <= 1'b0;
`ifdef SEG_SCAN_DP_EN
            pend_dp  <= '0;
            disp_dp  <= '0;
`endif
        end else begin
            xfer_d   <= wrap && pend;
            upd_done <= xfer_d;
            if (wrap && pend) begin
                disp_reg <= pend_reg;
                pend     <= 1'b0;
`ifdef SEG_SCAN_DP_EN
                disp_dp  <= pend_dp;
`endif
            end else if (load && !pend) begin
                pend_reg <= value;
                pend     <= 1'b1;
`ifdef SEG_SCAN_DP_EN
                pend_dp  <= dp_mask;
`endif
            end
        end
    end

    // Current nibble, leading-zero map (bit k set when nibbles k..top are
    // all zero), blanking decision and one-hot digit select.
    always_comb begin : sel_logic
        logic run;
        nib     = disp_reg[4*idx +: 4];
        run     = 1'b1;
        zero_up = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            run        = run & (disp_reg[4*k +: 4] == 4'h0);
            zero_up[k] = run;
        end
        blank_now   = blank_lz && (idx != '0) && zero_up[idx];
        an_next     = '0;
        an_next[idx] = 1'b1;
    end

    // Registered display outputs; they go dark on the edge after en drops.
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            an  <= '0;
            seg <= '0;
`ifdef SEG_SCAN_DP_EN
            dp  <= 1'b0;
`endif
        end else begin
            an  <= an_next;
            seg <= blank_now ? 7'h00 : hex_decode(nib);
`ifdef SEG_SCAN_DP_EN
            dp  <= disp_dp[idx];
`endif
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: self-checking bench for seg_scan_driver with
// DIGITS=4 and PRESCALE=4. A cycle model pushes the expected outputs on
// each rising edge, and the scoreboard pops and compares them on the
// falling edge. Directed checks cover the listed display scenarios.
module tb_seg_scan_driver;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 4;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        en       = 1'b0;
    logic        load     = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] value    = '0;
    logic        ready;
    logic        upd_done;
    logic [3:0]  an;
    logic [6:0]  seg;
`ifdef SEG_SCAN_DP_EN
    logic [3:0]  dp_mask  = '0;
    logic        dp;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int upd_cnt  = 0;
    logic [12:0] exp_q[$];

    // Model state; it mirrors the DUT state during the current cycle.
    int          m_pcnt = 0;
    int          m_idx  = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pval = '0;
    logic        m_pend = 1'b0;
    logic        m_xd   = 1'b0;

    // Clock generation.
    always #5 clk = ~clk;

    seg_scan_driver #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .load     (load),
        .value    (value),
        .blank_lz (blank_lz),
`ifdef SEG_SCAN_DP_EN
        .dp_mask  (dp_mask),
        .dp       (dp),
`endif
        .ready    (ready),
        .upd_done (upd_done),
        .an       (an),
        .seg      (seg)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        logic [6:0] tbl [16];
        tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        return tbl[n];
    endfunction

    // Cycle model: compute the outputs this edge produces, update state, and push.
    always @(posedge clk) begin : model
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_upd;
        logic       tk;
        logic       wr;
        int         hi;
        if (!rst_n) begin
            m_pcnt = 0; m_idx = 0; m_disp = '0; m_pval = '0;
            m_pend = 1'b0; m_xd = 1'b0;
            e_an = '0; e_seg = '0; e_upd = 1'b0;
        end else begin
            e_upd = m_xd;
            e_an  = '0;
            e_seg = '0;
            if (en) begin
                hi = -1;
                for (int k = 0; k < DIGITS; k++)
                    if (m_disp[4*k +: 4] != 4'h0) hi = k;
                e_an = 4'b0001 << m_idx;
                if (blank_lz && m_idx > 0 && m_idx > hi) e_seg = 7'h00;
                else e_seg = ref_seg(m_disp[4*m_idx +: 4]);
            end
            tk   = en && (m_pcnt == PRESCALE - 1);
            wr   = tk && (m_idx == DIGITS - 1);
            m_xd = wr && m_pend;
            if (wr && m_pend) begin
                m_disp = m_pval;
                m_pend = 1'b0;
            end else if (load && !m_pend) begin
                m_pval = value;
                m_pend = 1'b1;
            end
            if (en) begin
                if (tk) begin
                    m_pcnt = 0;
                    m_idx  = (m_idx + 1) % DIGITS;
                end else begin
                    m_pcnt = m_pcnt + 1;
                end
            end
        end
        exp_q.push_back({~m_pend, e_upd, e_an, e_seg});
    end

    // Scoreboard: pop the expected outputs and compare them with the DUT.
    always @(negedge clk) begin : scoreboard
        logic [12:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("sb_ready", 32'(ready), 32'(e[12]));
            check_val("sb_upd", 32'(upd_done), 32'(e[11]));
            check_val("sb_an", 32'(an), 32'(e[10:7]));
            check_val("sb_seg", 32'(seg), 32'(e[6:0]));
        end
    end

    // Count upd_done pulses, and check that each digit stays lit for PRESCALE cycles.
    always @(negedge clk) begin : run_mon
        static logic [3:0] last_an = '0;
        static int         run_len = 0;
        static logic       run_ok  = 1'b0;
        if (upd_done === 1'b1) upd_cnt++;
        if (!rst_n) begin
            last_an = '0; run_len = 0; run_ok = 1'b0;
        end else if (an !== 4'b0000) begin
            if (an === last_an) begin
                run_len++;
            end else begin
                if (run_ok) check_val("slot_len", 32'(run_len), 32'(PRESCALE));
                last_an = an; run_len = 1; run_ok = 1'b1;
            end
        end
    end

    task automatic wait_negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) until digit d is selected, then check its segments.
    task automatic check_digit(input int d, input logic [6:0] exp, input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (an === (4'b0001 << d)) break;
        end
        check_val(tag, {21'd0, an, seg}, {21'd0, 4'b0001 << d, exp});
    endtask

    // Wait (bounded) for upd_done, and check that new digit 0 shows in the same cycle.
    task automatic wait_upd(input logic [6:0] exp0, input string tag);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (upd_done === 1'b1) break;
        end
        check_val(tag, 32'(upd_done), 32'd1);
        check_val({tag, "_d0"}, {21'd0, an, seg}, {21'd0, 4'b0001, exp0});
    endtask

    // Wait (bounded) until the model's pcnt equals p (and its idx equals i, if i >= 0).
    task automatic wait_state(input int p, input int i, input string tag);
        int ok;
        ok = 0;
        for (int c = 0; c < 40; c++) begin
            if (m_pcnt == p && (i < 0 || m_idx == i)) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (ok == 0) check_val(tag, 32'd0, 32'd1);
    endtask

    // Single-cycle load request.
    task automatic do_load(input logic [15:0] v);
        load  = 1'b1;
        value = v;
        @(negedge clk);
        load  = 1'b0;
    endtask

    initial begin : stim
        int u0;
        int cnt;
        int frz_idx;

        // Reset held two cycles with en=1.
        en = 1'b1;
        wait_negs(2);
        check_val("rst_an", 32'(an), 32'd0);
        check_val("rst_seg", 32'(seg), 32'd0);
        check_val("rst_ready", 32'(ready), 32'd1);
        check_val("rst_upd", 32'(upd_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("first_an", 32'(an), 32'd1);
        check_val("first_seg", 32'(seg), 32'h7E);

        // Free scanning with no load.
        wait_negs(36);

        // Load 1234 mid-frame, then try FFFF while busy.
        wait_negs(5);
        u0 = upd_cnt;
        do_load(16'h1234);
        check_val("ready_after_load", 32'(ready), 32'd0);
        do_load(16'hFFFF);
        check_val("ready_busy", 32'(ready), 32'd0);
        wait_upd(7'h33, "upd_1234");
        check_digit(0, 7'h33, "d0_1234");
        check_digit(1, 7'h79, "d1_1234");
        check_digit(2, 7'h6D, "d2_1234");
        check_digit(3, 7'h30, "d3_1234");
        check_val("ready_back", 32'(ready), 32'd1);
        check_val("upd_once", 32'(upd_cnt - u0), 32'd1);

        // Load ABCD on the wrap-tick cycle: it shows only after the next wrap.
        wait_state(PRESCALE - 1, DIGITS - 1, "wrap_wait");
        load  = 1'b1;
        value = 16'hABCD;
        cnt   = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) load = 1'b0;
            if (cnt == 3) check_val("wrap_load_old", {21'd0, an, seg}, {21'd0, 4'b0001, 7'h33});
            if (upd_done === 1'b1) break;
        end
        check_val("wrap_load_latency", 32'(cnt), 32'(DIGITS * PRESCALE + 2));
        check_digit(0, 7'h3D, "d0_abcd");
        check_digit(1, 7'h4E, "d1_abcd");
        check_digit(2, 7'h1F, "d2_abcd");
        check_digit(3, 7'h77, "d3_abcd");

        // Leading-zero blanking.
        blank_lz = 1'b1;
        do_load(16'h0050);
        wait_upd(7'h7E, "upd_0050");
        check_digit(1, 7'h5B, "d1_0050");
        check_digit(2, 7'h00, "d2_0050");
        check_digit(3, 7'h00, "d3_0050");
        do_load(16'h0000);
        wait_upd(7'h7E, "upd_0000");
        check_digit(1, 7'h00, "d1_0000");
        check_digit(2, 7'h00, "d2_0000");
        check_digit(3, 7'h00, "d3_0000");
        blank_lz = 1'b0;

        // Enable dropped mid-slot; scanning resumes on the same digit.
        wait_state(1, -1, "mid_slot_wait");
        frz_idx = m_idx;
        en = 1'b0;
        @(negedge clk);
        check_val("en_off_an", 32'(an), 32'd0);
        check_val("en_off_seg", 32'(seg), 32'd0);
        wait_negs(5);
        check_val("en_off_hold", 32'(an), 32'd0);
        en = 1'b1;
        @(negedge clk);
        check_val("resume_digit", 32'(an), 32'(4'b0001 << frz_idx));
        wait_negs(20);

        // Reset while a value is pending discards it.
        do_load(16'h5678);
        check_val("pend_before_rst", 32'(ready), 32'd0);
        rst_n = 1'b0;
        wait_negs(2);
        check_val("rst_pend_ready", 32'(ready), 32'd1);
        rst_n = 1'b1;
        u0 = upd_cnt;
        wait_negs(2);
        check_digit(0, 7'h7E, "d0_after_rst");
        check_digit(1, 7'h7E, "d1_after_rst");
        check_digit(2, 7'h7E, "d2_after_rst");
        check_digit(3, 7'h7E, "d3_after_rst");
        wait_negs(20);
        check_val("no_upd_after_rst", 32'(upd_cnt - u0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
